// File: rtl/regn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regn_ctrl_pkg
// Shared encodings for the regN sequencing controller:
//   - operation / mode encoding (matches regN's internal state encoding)
//   - controller FSM state encoding
//   - requester identifiers used by the arbiter and the grant decode
// -----------------------------------------------------------------------------
package regn_ctrl_pkg;

  // regN mode and requested operation share one encoding, so a requested op
  // can be compared directly against the mirrored mode.
  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_INC  = 1'b1;

  // Requester ids. REQ_B is the reset value of the last-granted register,
  // which gives requester A first priority out of reset.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_ISSUE  = 2'd2
  } state_t;

endpackage

// File: rtl/regn_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter, purely combinational.
// Ports:
//   i_req[1:0] : request levels, bit 0 = requester A, bit 1 = requester B
//   i_last     : id of the requester granted most recently
//   o_vld      : at least one request is pending
//   o_id       : id of the winning requester (meaningful only when o_vld)
// -----------------------------------------------------------------------------
module rr_arb2
  import regn_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_id
);

  always_comb begin
    o_vld = |i_req;
    o_id  = REQ_A;
    case (i_req)
      2'b01:   o_id = REQ_A;
      2'b10:   o_id = REQ_B;
      // Contention: the requester that was not served last time wins.
      2'b11:   o_id = (i_last == REQ_A) ? REQ_B : REQ_A;
      default: o_id = REQ_A;
    endcase
  end

endmodule

// File: rtl/regn_ctrl.sv
// -----------------------------------------------------------------------------
// regn_ctrl
// Sequencing controller and two-port arbiter in front of one regN
// load/increment register. Requests from A and B are serialised round-robin.
// A mirror of regN's mode is kept; because regN adopts a new mode one cycle
// after select is driven, an extra SWITCH cycle is inserted before any
// operation whose mode differs from the current one.
//
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   req_a/op_a/data_a/gnt_a    : requester A (level req, op 0=LOAD 1=INC,
//                                load data, one-cycle grant pulse)
//   req_b/op_b/data_b/gnt_b    : requester B, same meaning
//   reg_in/reg_ld_inc/reg_select : drive regN's in, ld_inc and select
//   busy                       : controller is not in IDLE
//
// All outputs decode registered state only; requester inputs reach outputs
// only through registers.
// -----------------------------------------------------------------------------
module regn_ctrl
  import regn_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             op_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic             op_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic [WIDTH-1:0] reg_in,
  output logic             reg_ld_inc,
  output logic             reg_select,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic             r_mode;
  logic             r_last;
  logic             r_win_id;
  logic             r_win_op;
  logic [WIDTH-1:0] r_win_data;

  logic             w_arb_vld;
  logic             w_arb_id;
  logic             w_arb_op;
  logic [WIDTH-1:0] w_arb_data;

  rr_arb2 u_arb (
    .i_req  ({req_b, req_a}),
    .i_last (r_last),
    .o_vld  (w_arb_vld),
    .o_id   (w_arb_id)
  );

  // Operation and payload of the current arbitration winner.
  assign w_arb_op   = (w_arb_id == REQ_B) ? op_b   : op_a;
  assign w_arb_data = (w_arb_id == REQ_B) ? data_b : data_a;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Mode mirror, round-robin history and winner latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= OP_LOAD;
      r_last     <= REQ_B;
      r_win_id   <= REQ_A;
      r_win_op   <= OP_LOAD;
      r_win_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_vld) begin
            r_win_id   <= w_arb_id;
            r_win_op   <= w_arb_op;
            r_win_data <= w_arb_data;
          end
        end
        // regN takes the mode driven on select during this cycle, so the
        // mirror follows at the same edge.
        ST_SWITCH: r_mode <= r_win_op;
        ST_ISSUE:  r_last <= r_win_id;
        default: ;
      endcase
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next     = r_state;
    reg_in     = '0;
    reg_ld_inc = 1'b0;
    reg_select = r_mode;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_arb_vld) begin
          w_next = (w_arb_op == r_mode) ? ST_ISSUE : ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        // Present the new mode one cycle ahead of the operation.
        reg_select = r_win_op;
        w_next     = ST_ISSUE;
      end
      ST_ISSUE: begin
        reg_ld_inc = 1'b1;
        reg_in     = r_win_data;
        gnt_a      = (r_win_id == REQ_A);
        gnt_b      = (r_win_id == REQ_B);
        w_next     = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/regn_ctrl.md
# regn_ctrl

Sequencing controller and two-port arbiter for one regN load/increment register. Two requesters each ask for a LOAD (write `data`) or an INC (register + 1). `regn_ctrl` serialises the requests round-robin and keeps a mirror of regN's internal mode. Because regN changes mode one cycle after `select` is driven, the controller inserts a mode-switch cycle before any operation whose mode differs from the current one. It sits between the requesting units and a regN instance of the same WIDTH, and drives that instance's `in`, `ld_inc` and `select`.

## Interface
- WIDTH, 8, datapath width; must equal the WIDTH of the controlled regN.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_a  in  1  requester A operation request; level, held until gnt_a.
- op_a  in  1  requester A op: 0 = LOAD, 1 = INC.
- data_a  in  WIDTH  requester A load value; ignored for INC.
- gnt_a  out  1  one-cycle pulse in the cycle A's operation is applied.
- req_b, op_b, data_b, gnt_b: same as A, for requester B.
- reg_in  out  WIDTH  to regN `in`.
- reg_ld_inc  out  1  to regN `ld_inc`.
- reg_select  out  1  to regN `select`.
- busy  out  1  high whenever the controller is not in IDLE.

## Operation
- Registered state:
  - FSM state: IDLE, SWITCH, ISSUE.
  - mode_q: mirrors regN's mode, LOAD = 0, INC = 1.
  - last_q: last-granted requester.
  - Latched win_id, win_op, win_data.
- IDLE:
  - reg_ld_inc = 0; reg_select = mode_q.
  - If any req is high, pick a winner and latch its id, op and data.
  - If win_op == mode_q, go to ISSUE; otherwise go to SWITCH.
  - If no req is high, stay in IDLE.
- SWITCH:
  - reg_select = win_op; reg_ld_inc = 0.
  - mode_q <= win_op; go to ISSUE.
- ISSUE:
  - reg_select = mode_q; reg_ld_inc = 1; reg_in = win_data.
  - Pulse gnt for win_id; last_q <= win_id; go to IDLE.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: the one that is not last_q wins.
- Outside ISSUE, reg_in = 0.
- Requester rules:
  - req, op and data must be stable from assertion until the gnt cycle.
  - A requester that saw gnt at edge t must present req low in cycle t+1, unless it is issuing a new request.
  - A new request may be raised in the cycle immediately after gnt.
- INC wraps modulo 2^WIDTH inside regN (0xFF + 1 = 0x00 for WIDTH 8). The controller does no arithmetic.
- Reset, whenever asserted, including mid-SWITCH or mid-ISSUE:
  - state = IDLE, mode_q = LOAD, last_q = B (A has first priority).
  - win regs = 0; all outputs 0.
  - No gnt is issued for the aborted request. Requesters still holding req are re-arbitrated after release.
  - regN and regn_ctrl share rst, so the mode mirror stays consistent.

## Timing
- Reset values: gnt_a = gnt_b = 0, reg_in = 0, reg_ld_inc = 0, reg_select = 0, busy = 0.
- Same-mode op: accepted in IDLE at cycle n, ISSUE and gnt at n+1, regN `out` updated after the edge ending n+1. Latency is 2 cycles from accept to gnt.
- Mode-change op: IDLE at n, SWITCH at n+1, ISSUE and gnt at n+2. Latency is 3 cycles.
- Maximum throughput is one op per 2 cycles (IDLE/ISSUE alternate).
- gnt_a and gnt_b are never high together. reg_ld_inc is high exactly in gnt cycles.
- Outputs are combinational decodes of registered state only; no input-to-output combinational paths.

## Structure
- Package `regn_ctrl_pkg` holds:
  - OP_LOAD = 1'b0 and OP_INC = 1'b1, matching regN's state encoding.
  - The FSM state encoding (IDLE, SWITCH, ISSUE).
  - Requester ids REQ_A, REQ_B.
- Sub-module `rr_arb2`: two-input round-robin arbiter.
  - Inputs: req[1:0], last id.
  - Outputs: grant valid, grant id (combinational).
  - The FSM, mode mirror and latches stay in `regn_ctrl`.
- The test bench instantiates `regn_ctrl` and `regN` together and checks regN `out`.

## Test plan
- Reset release, req_a LOAD 0x3C: IDLE → ISSUE, reg_ld_inc = 1, reg_select = 0, gnt_a 2nd cycle; out = 0x3C.
- Then req_b INC: SWITCH cycle (reg_select = 1, reg_ld_inc = 0), gnt_b on the 3rd cycle; out = 0x3D; mode_q = INC.
- A INC issued twice back-to-back after that: no SWITCH, gnt_a every 2 cycles; out 0x3E then 0x3F.
- req_a (INC) and req_b (INC) held continuously from reset with mode INC preset: grants alternate A, B, A, B; never simultaneous; out increments by 1 per gnt.
- req_b LOAD 0xFF, then INC: SWITCH before each op; out 0xFF then 0x00 (wrap).
- rst pulsed low during SWITCH: all outputs 0 immediately, no gnt, mode_q = LOAD; after release the held request is re-arbitrated and completes with correct latency.
